// File: rtl/reg_file_ram.sv
// Word-addressed flop-based RAM: one write port, one registered read port with
// write-first bypass, and a self-timed clear sequencer that reports busy while it runs.
module reg_file_ram #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata,
    output logic              rvalid,
    input  logic              clr_req,
    output logic              busy
);

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [WIDTH-1:0]    r_rdata;
    logic                r_rvalid;
    logic                r_busy;
    logic [ADDR_W-1:0]   r_clr_ptr;

    logic                w_busy_nxt;
    logic [ADDR_W-1:0]   w_clr_ptr_nxt;
    logic                w_wr_en;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic [WIDTH-1:0]    w_wr_data;
    logic                w_rd_en;
    logic                w_waddr_ok;
    logic                w_bypass;
    logic [WIDTH-1:0]    w_rd_word;

    assign w_waddr_ok = ({1'b0, waddr} < LP_DEPTH);
    assign w_bypass   = we && w_waddr_ok && (raddr == waddr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_busy_nxt    = r_busy;
        w_clr_ptr_nxt = r_clr_ptr;
        w_wr_en       = 1'b0;
        w_wr_addr     = waddr;
        w_wr_data     = wdata;
        w_rd_en       = 1'b0;
        case (r_state)
            IDLE: begin
                // A clear request wins; any write or read in the same cycle is dropped.
                if (clr_req) begin
                    w_state_nxt   = CLEAR;
                    w_busy_nxt    = 1'b1;
                    w_clr_ptr_nxt = '0;
                end else begin
                    w_wr_en = we;
                    w_rd_en = re;
                end
            end
            CLEAR: begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_clr_ptr;
                w_wr_data = '0;
                if (r_clr_ptr == LP_LAST) begin
                    w_state_nxt   = IDLE;
                    w_busy_nxt    = 1'b0;
                    w_clr_ptr_nxt = '0;
                end else begin
                    w_clr_ptr_nxt = r_clr_ptr + 1'b1;
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_busy_nxt    = 1'b0;
                w_clr_ptr_nxt = '0;
            end
        endcase
    end

    // Out-of-range read addresses match no word and fall through to zero.
    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr == ADDR_W'(i)) begin
                w_rd_word = r_mem[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr_en && (w_wr_addr == ADDR_W'(i))) begin
                    r_mem[i] <= w_wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata   <= '0;
            r_rvalid  <= 1'b0;
            r_busy    <= 1'b0;
            r_clr_ptr <= '0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_clr_ptr <= w_clr_ptr_nxt;
            r_rvalid  <= w_rd_en;
            if (w_rd_en) begin
                r_rdata <= w_bypass ? wdata : w_rd_word;
            end
        end
    end

    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
    assign busy   = r_busy;

endmodule

// File: tb/tb_reg_file_ram.sv
// Directed self-checking bench for reg_file_ram: a 16-word instance for the main
// scenarios and a 10-word instance for the non-power-of-two depth.
module tb_reg_file_ram;

    logic       clk;
    logic       clk_en;
    logic       rst_n;

    logic       a_we, a_re, a_clr;
    logic [3:0] a_waddr, a_raddr;
    logic [7:0] a_wdata, a_rdata;
    logic       a_rvalid, a_busy;

    logic       b_we, b_re, b_clr;
    logic [3:0] b_waddr, b_raddr;
    logic [7:0] b_wdata, b_rdata;
    logic       b_rvalid, b_busy;

    int n_checks;
    int n_fail;

    reg_file_ram #(.WIDTH(8), .DEPTH(16), .ADDR_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .we(a_we), .waddr(a_waddr), .wdata(a_wdata),
        .re(a_re), .raddr(a_raddr), .rdata(a_rdata), .rvalid(a_rvalid),
        .clr_req(a_clr), .busy(a_busy)
    );

    reg_file_ram #(.WIDTH(8), .DEPTH(10), .ADDR_W(4)) u_dut10 (
        .clk(clk), .rst_n(rst_n),
        .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
        .re(b_re), .raddr(b_raddr), .rdata(b_rdata), .rvalid(b_rvalid),
        .clr_req(b_clr), .busy(b_busy)
    );

    // Gated clock so the reset test can run with no edges at all.
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic a_write(input logic [3:0] addr, input logic [7:0] data);
        @(negedge clk);
        a_we = 1'b1; a_waddr = addr; a_wdata = data;
        @(posedge clk); #1;
        a_we = 1'b0;
    endtask

    task automatic a_read(input logic [3:0] addr, output logic [7:0] data, output logic vld);
        @(negedge clk);
        a_re = 1'b1; a_raddr = addr;
        @(posedge clk); #1;
        a_re = 1'b0;
        data = a_rdata; vld = a_rvalid;
    endtask

    task automatic b_write(input logic [3:0] addr, input logic [7:0] data);
        @(negedge clk);
        b_we = 1'b1; b_waddr = addr; b_wdata = data;
        @(posedge clk); #1;
        b_we = 1'b0;
    endtask

    task automatic b_read(input logic [3:0] addr, output logic [7:0] data, output logic vld);
        @(negedge clk);
        b_re = 1'b1; b_raddr = addr;
        @(posedge clk); #1;
        b_re = 1'b0;
        data = b_rdata; vld = b_rvalid;
    endtask

    initial begin
        logic [7:0] rd;
        logic       v;
        int         cnt;

        n_checks = 0; n_fail = 0;
        clk_en = 1'b1; rst_n = 1'b0;
        a_we = 0; a_re = 0; a_clr = 0; a_waddr = 0; a_raddr = 0; a_wdata = 0;
        b_we = 0; b_re = 0; b_clr = 0; b_waddr = 0; b_raddr = 0; b_wdata = 0;
        #1;
        chk("por_busy", 32'(a_busy), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset with the clock stopped after leaving non-zero state behind.
        a_write(4'd3, 8'hA5);
        a_write(4'd12, 8'h3C);
        a_read(4'd3, rd, v);
        @(negedge clk);
        clk_en = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_rdata", 32'(a_rdata), 32'h0);
        chk("rst_rvalid", 32'(a_rvalid), 32'h0);
        chk("rst_busy", 32'(a_busy), 32'h0);
        #2 rst_n = 1'b1;
        #4 clk_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a_read(4'(i), rd, v);
            chk($sformatf("rst_word%0d", i), 32'(rd), 32'h0);
        end

        // Write then read, then rdata holds with re low.
        a_write(4'd3, 8'hA5);
        a_read(4'd3, rd, v);
        chk("wr_rd_data", 32'(rd), 32'hA5);
        chk("wr_rd_vld", 32'(v), 32'h1);
        @(posedge clk); #1;
        chk("idle_vld", 32'(a_rvalid), 32'h0);
        chk("idle_hold", 32'(a_rdata), 32'hA5);

        // Write-first bypass on a same-address write and read.
        a_write(4'd7, 8'h11);
        @(negedge clk);
        a_we = 1'b1; a_waddr = 4'd7; a_wdata = 8'h5C;
        a_re = 1'b1; a_raddr = 4'd7;
        @(posedge clk); #1;
        a_we = 1'b0; a_re = 1'b0;
        chk("byp_data", 32'(a_rdata), 32'h5C);
        chk("byp_vld", 32'(a_rvalid), 32'h1);
        a_read(4'd7, rd, v);
        chk("byp_stored", 32'(rd), 32'h5C);

        // Clear sequence: busy length, ignored traffic, all words zero.
        for (int i = 0; i < 16; i++) a_write(4'(i), 8'hFF);
        @(negedge clk);
        a_clr = 1'b1;
        @(posedge clk); #1;
        a_clr = 1'b0;
        chk("clr_busy_start", 32'(a_busy), 32'h1);
        cnt = 1;
        for (int i = 0; i < 40 && a_busy; i++) begin
            @(negedge clk);
            if (i == 3) begin
                a_we = 1'b1; a_waddr = 4'd2; a_wdata = 8'h33;
                a_re = 1'b1; a_raddr = 4'd5; a_clr = 1'b1;
            end
            @(posedge clk); #1;
            a_we = 1'b0; a_re = 1'b0; a_clr = 1'b0;
            if (i == 3) begin
                chk("clr_rvalid", 32'(a_rvalid), 32'h0);
                chk("clr_rdata_hold", 32'(a_rdata), 32'h5C);
            end
            if (a_busy) cnt++;
        end
        chk("clr_cycles", 32'(cnt), 32'd16);
        for (int i = 0; i < 16; i++) begin
            a_read(4'(i), rd, v);
            chk($sformatf("clr_word%0d", i), 32'(rd), 32'h0);
        end

        // Reset in the middle of a clear.
        for (int i = 0; i < 16; i++) a_write(4'(i), 8'hFF);
        @(negedge clk);
        a_clr = 1'b1;
        @(posedge clk); #1;
        a_clr = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(a_busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a_read(4'(i), rd, v);
            chk($sformatf("mid_rst_word%0d", i), 32'(rd), 32'h0);
        end
        chk("mid_rst_idle", 32'(a_busy), 32'h0);
        a_write(4'd9, 8'h42);
        a_read(4'd9, rd, v);
        chk("mid_rst_wr", 32'(rd), 32'h42);

        // Ten-word instance: out-of-range access and shorter clear.
        b_write(4'd9, 8'hAA);
        b_write(4'd12, 8'h77);
        b_read(4'd12, rd, v);
        chk("d10_oor_data", 32'(rd), 32'h0);
        chk("d10_oor_vld", 32'(v), 32'h1);
        b_read(4'd2, rd, v);
        chk("d10_alias2", 32'(rd), 32'h0);
        b_read(4'd4, rd, v);
        chk("d10_alias4", 32'(rd), 32'h0);
        b_read(4'd9, rd, v);
        chk("d10_top", 32'(rd), 32'hAA);
        @(negedge clk);
        b_clr = 1'b1;
        @(posedge clk); #1;
        b_clr = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40 && b_busy; i++) begin
            cnt++;
            @(posedge clk); #1;
        end
        chk("d10_clr_cycles", 32'(cnt), 32'd10);
        b_read(4'd9, rd, v);
        chk("d10_clr_top", 32'(rd), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
